// File: rtl/dffram256x16_2r1w.sv
// 256 x 16 flip-flop register file: port 0 read/write with byte enables, port 1 read-only.
// Both read ports are read-first and registered; reset clears only the output registers.
module dffram256x16_2r1w (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        EN0,
  input  logic [7:0]  A0,
  input  logic [15:0] Di0,
  input  logic [1:0]  WE0,
  output logic [15:0] Do0,
  input  logic        EN1,
  input  logic [7:0]  A1,
  output logic [15:0] Do1
);

  logic [15:0] mem [256];

  // Storage has no reset; writes are suppressed while RST_N is low.
  always_ff @(posedge CLK) begin
    if (RST_N && EN0) begin
      if (WE0[0]) mem[A0][7:0]  <= Di0[7:0];
      if (WE0[1]) mem[A0][15:8] <= Di0[15:8];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      Do0 <= 16'h0000;
      Do1 <= 16'h0000;
    end else begin
      if (EN0) Do0 <= mem[A0];
      if (EN1) Do1 <= mem[A1];
    end
  end

endmodule

// File: tb/tb_dffram256x16_2r1w.sv
// Scoreboard bench for dffram256x16_2r1w: directed scenarios plus random traffic
// against an array model with per-bit "known" masks for never-written locations.
module tb_dffram256x16_2r1w;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en0, en1;
  logic [7:0]  a0, a1;
  logic [15:0] di0;
  logic [1:0]  we0;
  logic [15:0] do0, do1;

  always #5 clk = ~clk;

  dffram256x16_2r1w dut (
    .CLK(clk), .RST_N(rst_n),
    .EN0(en0), .A0(a0), .Di0(di0), .WE0(we0), .Do0(do0),
    .EN1(en1), .A1(a1), .Do1(do1)
  );

  typedef struct {
    logic [15:0] e0;
    logic [15:0] m0;
    logic [15:0] e1;
    logic [15:0] m1;
  } exp_t;

  exp_t sb[$];

  logic [15:0] ref_mem  [256];
  logic [15:0] ref_known[256];
  logic [15:0] cur_e0 = '0, cur_m0 = '0, cur_e1 = '0, cur_m1 = '0;

  int n_cmp = 0;
  int n_bad = 0;

  // One clock of stimulus; the expectation for the outputs after this edge is queued.
  task automatic cyc(input logic r, input logic e0, input logic [7:0] ad0,
                     input logic [15:0] d0, input logic [1:0] w0,
                     input logic e1, input logic [7:0] ad1);
    logic [15:0] bm;
    exp_t x;
    @(negedge clk);
    rst_n = r; en0 = e0; a0 = ad0; di0 = d0; we0 = w0; en1 = e1; a1 = ad1;
    if (!r) begin
      cur_e0 = 16'h0; cur_m0 = 16'hFFFF;
      cur_e1 = 16'h0; cur_m1 = 16'hFFFF;
    end else begin
      if (e0) begin cur_e0 = ref_mem[ad0]; cur_m0 = ref_known[ad0]; end
      if (e1) begin cur_e1 = ref_mem[ad1]; cur_m1 = ref_known[ad1]; end
      if (e0) begin
        bm = {{8{w0[1]}}, {8{w0[0]}}};
        ref_mem[ad0]   = (ref_mem[ad0] & ~bm) | (d0 & bm);
        ref_known[ad0] = ref_known[ad0] | bm;
      end
    end
    x.e0 = cur_e0; x.m0 = cur_m0; x.e1 = cur_e1; x.m1 = cur_m1;
    sb.push_back(x);
  endtask

  task automatic rd0(input logic [7:0] ad);
    cyc(1'b1, 1'b1, ad, 16'h0, 2'b00, 1'b0, 8'h00);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        if (x.m0 != 16'h0) begin
          n_cmp++;
          if ((do0 & x.m0) !== (x.e0 & x.m0)) begin
            n_bad++;
            $display("FAIL do0 t=%0t got=%h expected=%h (mask %h)", $time, do0, x.e0, x.m0);
          end
        end
        if (x.m1 != 16'h0) begin
          n_cmp++;
          if ((do1 & x.m1) !== (x.e1 & x.m1)) begin
            n_bad++;
            $display("FAIL do1 t=%0t got=%h expected=%h (mask %h)", $time, do1, x.e1, x.m1);
          end
        end
      end
    end
  end

  initial begin : stim
    int k;
    for (int i = 0; i < 256; i++) begin ref_mem[i] = '0; ref_known[i] = '0; end
    rst_n = 1'b0; en0 = 0; en1 = 0; a0 = 0; a1 = 0; di0 = 0; we0 = 0;

    cyc(1'b0, 1'b0, 8'h00, 16'h0, 2'b00, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 8'h03, 16'hBEEF, 2'b11, 1'b1, 8'h03);

    for (int i = 0; i < 256; i++)
      cyc(1'b1, 1'b1, 8'(i), 16'(i), 2'b11, 1'b0, 8'h00);
    for (int i = 0; i < 256; i++) rd0(8'(i));
    for (int i = 0; i < 256; i++)
      cyc(1'b1, 1'b0, 8'(i), 16'hDEAD, 2'b11, 1'b1, 8'(255 - i));

    // Byte enables on word 5
    cyc(1'b1, 1'b1, 8'd5, 16'hAAAA, 2'b11, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 8'd5, 16'h1234, 2'b01, 1'b0, 8'h00);
    rd0(8'd5);
    cyc(1'b1, 1'b1, 8'd5, 16'h5678, 2'b10, 1'b0, 8'h00);
    rd0(8'd5);
    cyc(1'b1, 1'b1, 8'd5, 16'h9999, 2'b00, 1'b0, 8'h00);
    rd0(8'd5);

    // Enable gating: blocked write, then port 1 holds across address changes
    cyc(1'b1, 1'b0, 8'd7, 16'hFFFF, 2'b11, 1'b1, 8'd7);
    cyc(1'b1, 1'b1, 8'd7, 16'h0, 2'b00, 1'b0, 8'd20);
    cyc(1'b1, 1'b0, 8'd7, 16'h0, 2'b00, 1'b0, 8'd33);
    cyc(1'b1, 1'b0, 8'd7, 16'h0, 2'b00, 1'b0, 8'd44);

    // Same-address collision
    cyc(1'b1, 1'b1, 8'd9, 16'h0001, 2'b11, 1'b0, 8'd0);
    cyc(1'b1, 1'b1, 8'd9, 16'h0002, 2'b11, 1'b1, 8'd9);
    cyc(1'b1, 1'b1, 8'd9, 16'h0000, 2'b00, 1'b1, 8'd9);

    // Reset clears outputs but keeps storage
    cyc(1'b1, 1'b1, 8'd200, 16'h0, 2'b00, 1'b1, 8'd201);
    cyc(1'b0, 1'b1, 8'd200, 16'h7777, 2'b11, 1'b1, 8'd201);
    cyc(1'b1, 1'b0, 8'd0, 16'h0, 2'b00, 1'b0, 8'd0);
    cyc(1'b1, 1'b1, 8'd200, 16'h0, 2'b00, 1'b1, 8'd201);

    // Random traffic, biased to a small address window to provoke collisions
    for (int i = 0; i < 2000; i++) begin
      logic [7:0] ra0, ra1;
      ra0 = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      ra1 = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      cyc(($urandom_range(0, 63) != 0), 1'($urandom), ra0, 16'($urandom),
          2'($urandom), 1'($urandom), ra1);
    end

    cyc(1'b1, 1'b0, 8'h0, 16'h0, 2'b00, 1'b0, 8'h0);
    k = 0;
    while (sb.size() > 0 && k < 20) begin
      @(posedge clk);
      k++;
    end
    #2;
    if (sb.size() > 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
